// File: rtl/out_port_arbiter.sv
// Round-robin output-port arbiter: locks one input buffer onto the output link
// for a whole PKT_LEN-flit packet, then re-arbitrates after one idle cycle.
module out_port_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int PKT_LEN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_rdy,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_rdy,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(PKT_LEN + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   count_q, count_d;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cand;
  logic            g_valid;
  logic            xfer;
  logic            last_flit;

  // Round-robin search starting just after the previously served input.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!sel_found && in_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Grant is one-hot (or zero), so an OR of the masked slices is the mux.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) out_data = out_data | in_data[i*W +: W];
    end
  end

  assign g_valid   = |(grant_q & in_valid);
  assign xfer      = (state_q == LOCK) && g_valid && out_rdy;
  assign last_flit = (count_q == CW'(PKT_LEN - 1));

  // Reset cuts the handshake at once so an aborted packet loses no extra flit.
  assign in_rdy    = rst ? '0 : (grant_q & {N{out_rdy}});
  assign out_valid = !rst && g_valid;
  assign grant     = grant_q;
  assign busy      = (state_q == LOCK);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d          = LOCK;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
          count_d          = '0;
        end
      end
      LOCK: begin
        if (xfer) begin
          if (last_flit) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = gidx_q;
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Self-checking bench for out_port_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a packet-level reference model.
module tb_out_port_arbiter;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int PKT_LEN = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_rdy;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_rdy;
  logic [N-1:0]   grant;
  logic           busy;

  int checks = 0;
  int errors = 0;

  out_port_arbiter #(.N(N), .W(W), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_rdy(in_rdy), .out_valid(out_valid), .out_data(out_data),
    .out_rdy(out_rdy), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic [N-1:0]   iv;
    logic [N*W-1:0] data;
    logic           ordy;
    logic [N-1:0]   grant;
    logic           busy;
    logic           ov;
    logic [W-1:0]   od;
    logic [N-1:0]   rdy;
  } vec_t;

  vec_t tbl[11];

  // Reference model: which input owns the link, how many flits it has sent,
  // and who was served last. Sources present a per-input sequence number.
  bit m_locked;
  int m_g, m_last, m_cnt;
  int deliv[N];
  int seq[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] src_flit(input int i);
    return W'((i << 5) | (seq[i] & 31));
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] iv, input logic ordy);
    rst      = r;
    in_valid = iv;
    out_rdy  = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = src_flit(i);
  endtask

  task automatic compare_model();
    logic [N-1:0] eg, erdy;
    logic         eov;
    logic [W-1:0] eod;
    eg   = m_locked ? N'(1 << m_g) : '0;
    eov  = !rst && m_locked && in_valid[m_g];
    eod  = m_locked ? in_data[m_g*W +: W] : '0;
    erdy = (!rst && m_locked && out_rdy) ? N'(1 << m_g) : '0;
    check("m_grant", 32'(grant), 32'(eg));
    check("m_busy", 32'(busy), 32'(m_locked));
    check("m_out_valid", 32'(out_valid), 32'(eov));
    check("m_out_data", 32'(out_data), 32'(eod));
    check("m_in_rdy", 32'(in_rdy), 32'(erdy));
  endtask

  task automatic model_step();
    bit found;
    int idx;
    if (rst) begin
      m_locked = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_locked) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (!found && in_valid[idx]) begin
          found = 1; m_g = idx;
        end
      end
      if (found) begin
        m_locked = 1; m_cnt = 0;
      end
    end else if (in_valid[m_g] && out_rdy) begin
      deliv[m_g]++;
      seq[m_g]++;
      m_cnt++;
      if (m_cnt == PKT_LEN) begin
        m_locked = 0; m_last = m_g; m_cnt = 0;
      end
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input logic r, input logic [N-1:0] iv, input logic ordy, input int n);
    for (int c = 0; c < n; c++) begin
      drive(r, iv, ordy);
      #2;
      compare_model();
      finish_cycle();
    end
  endtask

  initial begin
    logic [N-1:0] gq[$];
    logic [N-1:0] prev, g;
    logic [W-1:0] held;
    int d0, zeros;

    tbl[0]  = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0001, 32'h00000011, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0001, 32'h00000011, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h11, 4'b0001};
    tbl[3]  = '{1'b0, 4'b0001, 32'h00000022, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h22, 4'b0001};
    tbl[4]  = '{1'b0, 4'b0001, 32'h00000033, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h33, 4'b0001};
    tbl[5]  = '{1'b0, 4'b0001, 32'h00000044, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h44, 4'b0001};
    tbl[6]  = '{1'b0, 4'b0001, 32'h00000055, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[7]  = '{1'b0, 4'b0000, 32'h00000055, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h55, 4'b0001};
    tbl[8]  = '{1'b1, 4'b0001, 32'h00000055, 1'b1, 4'b0001, 1'b1, 1'b0, 8'h55, 4'b0000};
    tbl[9]  = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[10] = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h11, 4'b0001};

    m_locked = 0; m_g = 0; m_last = N - 1; m_cnt = 0;
    for (int i = 0; i < N; i++) begin deliv[i] = 0; seq[i] = 0; end

    drive(1'b1, '0, 1'b0);
    @(posedge clk); #1;

    // Directed vectors: single requester, one-cycle bubble, reset while locked.
    for (int v = 0; v < 11; v++) begin
      rst = tbl[v].rst; in_valid = tbl[v].iv; in_data = tbl[v].data; out_rdy = tbl[v].ordy;
      #2;
      check($sformatf("v%0d_grant", v), 32'(grant), 32'(tbl[v].grant));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(tbl[v].busy));
      check($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(tbl[v].ov));
      check($sformatf("v%0d_out_data", v), 32'(out_data), 32'(tbl[v].od));
      check($sformatf("v%0d_in_rdy", v), 32'(in_rdy), 32'(tbl[v].rdy));
      finish_cycle();
    end

    // Wrap-around: serve input 2, then 0011 must go to input 0, then input 1.
    run(1'b1, '0, 1'b0, 1);
    run(1'b0, 4'b0100, 1'b1, 5);
    run(1'b0, 4'b0011, 1'b1, 1);
    check("wrap_first", 32'(grant), 32'h1);
    run(1'b0, 4'b0011, 1'b1, 5);
    check("wrap_second", 32'(grant), 32'h2);

    // Backpressure on input 1 after two flits.
    d0 = deliv[1];
    run(1'b0, 4'b0010, 1'b1, 2);
    held = src_flit(1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'b0010, 1'b0);
      #2;
      check("bp_in_rdy", 32'(in_rdy), 32'h0);
      check("bp_data_held", 32'(out_data), 32'(held));
      check("bp_grant", 32'(grant), 32'h2);
      compare_model();
      finish_cycle();
    end
    run(1'b0, 4'b0010, 1'b1, 2);
    check("bp_flits", 32'(deliv[1] - d0), 32'(PKT_LEN));
    check("bp_released", 32'(grant), 32'h0);

    // Source gap on input 3 while input 0 waits.
    run(1'b0, 4'b1000, 1'b1, 1);
    check("gap_grant", 32'(grant), 32'h8);
    run(1'b0, 4'b1000, 1'b1, 2);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'b0001, 1'b1);
      #2;
      check("gap_hold", 32'(grant), 32'h8);
      check("gap_out_valid", 32'(out_valid), 32'h0);
      compare_model();
      finish_cycle();
    end
    run(1'b0, 4'b1001, 1'b1, 2);
    check("gap_done", 32'(grant), 32'h0);
    run(1'b0, 4'b1001, 1'b1, 1);
    check("gap_next", 32'(grant), 32'h1);
    run(1'b0, 4'b0001, 1'b1, 4);

    // Reset after two of four flits.
    run(1'b0, 4'b0100, 1'b1, 3);
    drive(1'b1, 4'b0100, 1'b1);
    #2;
    check("rst_in_rdy_gated", 32'(in_rdy), 32'h0);
    compare_model();
    finish_cycle();
    drive(1'b0, 4'b1111, 1'b1);
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_rdy", 32'(in_rdy), 32'h0);
    compare_model();
    finish_cycle();
    check("rst_first", 32'(grant), 32'h1);

    // Saturated round-robin order and bubble count.
    gq.push_back(grant);
    prev = grant;
    zeros = 0;
    for (int c = 0; c < 20; c++) begin
      run(1'b0, 4'b1111, 1'b1, 1);
      g = grant;
      if (g == '0) zeros++;
      if (g != '0 && prev == '0) gq.push_back(g);
      prev = g;
    end
    check("sat_count", 32'(gq.size()), 32'd5);
    if (gq.size() == 5) begin
      check("sat_g0", 32'(gq[0]), 32'h1);
      check("sat_g1", 32'(gq[1]), 32'h2);
      check("sat_g2", 32'(gq[2]), 32'h4);
      check("sat_g3", 32'(gq[3]), 32'h8);
      check("sat_g4", 32'(gq[4]), 32'h1);
    end
    check("sat_bubbles", 32'(zeros), 32'd4);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      run(($urandom_range(0, 99) == 0), N'($urandom), ($urandom_range(0, 3) != 0), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
